// File: rtl/freq_meter_ctrl.sv
// Gated-count frequency meter controller: counts synchronised rising edges of
// sig_in over a gate whose length is picked manually or by auto-ranging.
//
// state | meaning
// IDLE  | waiting for start, published result held
// ARM   | 3 cycles: clear edge counter, let synchroniser drain, load gate timer
// GATE  | count edge pulses for the gate length of the working range
// LATCH | decide: shift range up/down and re-arm, or publish
// HOLD  | one cycle after publish, then re-arm (continuous) or go idle
module freq_meter_ctrl #(
    parameter int GATE_CYC = 100_000_000,
    parameter int CNT_W    = 24,
    parameter int LOW_TH   = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             continuous,
    input  logic             autorange,
    input  logic [1:0]       range_sel,
    input  logic             sig_in,
    output logic [CNT_W-1:0] freq_count,
    output logic [1:0]       range,
    output logic             valid,
    output logic             done,
    output logic             ovf,
    output logic             busy
);

    localparam int GW = $clog2(GATE_CYC + 1);
    localparam logic [GW-1:0]    GATE_LEN0 = GW'(GATE_CYC);
    localparam logic [GW-1:0]    GATE_LEN1 = GW'(GATE_CYC / 10);
    localparam logic [GW-1:0]    GATE_LEN2 = GW'(GATE_CYC / 100);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W:0]   LOW_TH_W  = (CNT_W + 1)'(LOW_TH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_GATE,
        S_LATCH,
        S_HOLD
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             sync_1;
    logic             sync_2;
    logic             sync_3;
    logic             edge_pulse;
    logic [1:0]       arm_cnt;
    logic [GW-1:0]    gate_cnt;
    logic [GW-1:0]    gate_len;
    logic [CNT_W-1:0] edge_cnt;
    logic             sat;
    logic [1:0]       work_range;
    logic [1:0]       range_clamped;
    logic             up_lock;
    logic             do_up;
    logic             do_down;
    logic             do_publish;

    assign edge_pulse    = sync_2 & ~sync_3;
    assign range_clamped = (range_sel == 2'd3) ? 2'd2 : range_sel;

    always_comb begin
        gate_len = GATE_LEN0;
        case (work_range)
            2'd1:    gate_len = GATE_LEN1;
            2'd2:    gate_len = GATE_LEN2;
            default: gate_len = GATE_LEN0;
        endcase
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start) state_nxt = S_ARM;
                S_ARM:   if (arm_cnt == 2'd0) state_nxt = S_GATE;
                S_GATE:  if (gate_cnt == GW'(1)) state_nxt = S_LATCH;
                S_LATCH: state_nxt = (do_up || do_down) ? S_ARM : S_HOLD;
                S_HOLD:  state_nxt = continuous ? S_ARM : S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs / decisions ----------------
    always_comb begin
        busy       = (state != S_IDLE);
        do_up      = 1'b0;
        do_down    = 1'b0;
        do_publish = 1'b0;
        if (state == S_LATCH && !abort) begin
            if (autorange && sat && work_range < 2'd2) begin
                do_up = 1'b1;
            end else if (autorange && ({1'b0, edge_cnt} < LOW_TH_W) &&
                         work_range > 2'd0 && !up_lock) begin
                do_down = 1'b1;
            end else begin
                do_publish = 1'b1;
            end
        end
    end

    // ARM lets the synchroniser drain naturally; nothing is counted outside GATE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            sync_3 <= 1'b0;
        end else begin
            sync_1 <= sig_in;
            sync_2 <= sync_1;
            sync_3 <= sync_2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm_cnt  <= 2'd2;
            gate_cnt <= '0;
        end else begin
            if (state != S_ARM) begin
                arm_cnt <= 2'd2;
            end else if (arm_cnt != 2'd0) begin
                arm_cnt <= arm_cnt - 2'd1;
            end
            if (state == S_ARM) begin
                gate_cnt <= gate_len;
            end else if (state == S_GATE) begin
                gate_cnt <= gate_cnt - GW'(1);
            end
        end
    end

    // sat marks an edge lost because the counter was already full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt <= '0;
            sat      <= 1'b0;
        end else if (state == S_ARM) begin
            edge_cnt <= '0;
            sat      <= 1'b0;
        end else if (state == S_GATE && edge_pulse) begin
            if (edge_cnt == CNT_MAX) begin
                sat <= 1'b1;
            end else begin
                edge_cnt <= edge_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_range <= 2'd0;
            up_lock    <= 1'b0;
        end else begin
            if (state == S_IDLE && start && !abort) begin
                if (!autorange) begin
                    work_range <= range_clamped;
                end
                up_lock <= 1'b0;
            end else if (do_up) begin
                work_range <= work_range + 2'd1;
                up_lock    <= 1'b1;
            end else if (do_down) begin
                work_range <= work_range - 2'd1;
            end
            if (state_nxt == S_IDLE) begin
                up_lock <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            freq_count <= '0;
            range      <= 2'd0;
            ovf        <= 1'b0;
            valid      <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= do_publish;
            if (do_publish) begin
                freq_count <= edge_cnt;
                range      <= work_range;
                ovf        <= sat;
                valid      <= 1'b1;
            end
        end
    end

endmodule

// File: doc/freq_meter_ctrl.md
FREQ_METER_CTRL -- requirements
Module: freq_meter_ctrl

Interface
REQ-001 Parameter GATE_CYC, default 100_000_000, range-0 gate length in clk cycles; range r gate = GATE_CYC/10^r, r in 0..2.
REQ-002 Parameter CNT_W, default 24, width of the edge counter and result.
REQ-003 Parameter LOW_TH, default 1000, auto-range down threshold.
REQ-004 Port clk  in  1  single clock; every flop is rising-edge clk.
REQ-005 Port rst_n  in  1  reset, asynchronous and active-low.
REQ-006 Port start  in  1  one-cycle request to begin a measurement; ignored while busy.
REQ-007 Port abort  in  1  return to IDLE at the next clk edge; no result is published.
REQ-008 Port continuous  in  1  if 1, re-arm automatically after each result.
REQ-009 Port autorange  in  1  if 1, range is chosen by the FSM; if 0, range_sel is used.
REQ-010 Port range_sel  in  2  manual range; value 3 is treated as 2.
REQ-011 Port sig_in  in  1  asynchronous signal under measurement.
REQ-012 Port freq_count  out  CNT_W  rising edges counted in the last published gate.
REQ-013 Port range  out  2  range of the published result.
REQ-014 Port valid  out  1  freq_count/range hold a published result.
REQ-015 Port done  out  1  one-cycle pulse when a result is published.
REQ-016 Port ovf  out  1  published result saturated.
REQ-017 Port busy  out  1  high in every state except IDLE.

Function
REQ-018 sig_in shall pass a 2-flop synchroniser and a rising-edge detector; each detected edge is one pulse, 3 clk cycles after the pin transition.
REQ-019 The FSM shall have states IDLE, ARM, GATE, LATCH, HOLD.
REQ-020 IDLE->ARM on start; the working range loads range_sel (clamped), or keeps the current range when autorange=1.
REQ-021 ARM shall last exactly 3 cycles, clearing the edge counter and flushing the synchroniser pipeline, then go to GATE.
REQ-022 GATE shall last exactly the gate length of the working range; only edge pulses asserted during GATE cycles are counted.
REQ-023 The edge counter shall saturate at 2^CNT_W-1 and set an internal sat flag; it shall never wrap.
REQ-024 GATE->LATCH after the final gate cycle.
REQ-025 In LATCH with autorange=1 and sat=1 and range<2: range+1, set up_lock, go to ARM, no publish.
REQ-026 In LATCH with autorange=1, count<LOW_TH, range>0 and up_lock=0: range-1, go to ARM, no publish.
REQ-027 Otherwise LATCH shall publish freq_count, range and ovf=sat, set valid, pulse done for 1 cycle, and go to HOLD.
REQ-028 HOLD shall go to ARM if continuous=1, else to IDLE, after 1 cycle; up_lock clears on entry to IDLE or on start.
REQ-029 If start and abort are sampled on the same edge, abort wins.
REQ-030 abort in any state shall go to IDLE with published outputs unchanged and done low.
REQ-031 Published outputs shall change only in LATCH; valid stays high until reset.

Reset
REQ-032 While rst_n=0, the block shall enter IDLE and force freq_count=0, range=0, valid=0, done=0, ovf=0, busy=0, clear all counters, synchroniser flops and up_lock.
REQ-033 On rst_n release, the first transition shall need a new start; reset mid-GATE discards the partial count.

Verification (sim: GATE_CYC=1000, CNT_W=8, LOW_TH=20)
REQ-034 Manual range 0, sig_in period 20 clk, start -> done once, freq_count=50, range=0, ovf=0, valid=1.
REQ-035 Autorange from range 0, sig_in period 2 clk -> range-0 gate saturates, no done, then range-1 gate publishes freq_count=50, range=1, ovf=0; no downshift follows.
REQ-036 Manual range 0, sig_in period 2 clk, autorange=0 -> freq_count=255, ovf=1.
REQ-037 continuous=1, period 20 clk -> done pulses every 1005 cycles (3 ARM + 1000 GATE + LATCH + HOLD), each with count 50; start held high while busy has no effect.
REQ-038 abort mid-GATE -> IDLE next cycle, busy=0, previous result unchanged; rst_n low mid-GATE -> all outputs 0.
